// File: rtl/uart_pkg.sv
// Shared UART definitions: link defaults, bit-period derivation, frame layout
// and receiver state encodings, common to uart_rx and uart_tx.
package uart_pkg;

  localparam int BAUD_RATE_DEFAULT   = 115_200;
  localparam int CLOCK_SPEED_DEFAULT = 50_000_000;
  localparam int COUNT_WIDTH         = 9;

  // Clock cycles per line bit; both ends of the link must derive it the same way.
  function automatic int baud_width(input int clock_speed, input int baud_rate);
    return clock_speed / baud_rate;
  endfunction

  typedef struct packed {
    logic       stop_bit;
    logic [7:0] payload;
    logic       start_bit;
  } packet_t;

  typedef enum int unsigned {
    IDLE_BIT  = 0,
    START_BIT = 1,
    DATA_BIT  = 2,
    STOP_BIT  = 3
  } state_bit_t;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit with a selectable reset value.
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= RESET_VALUE;
      q        <= RESET_VALUE;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a valid/ready holding register.
// Payload bits arrive inverted on the line and are re-inverted on capture.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_RATE   = BAUD_RATE_DEFAULT,
  parameter int CLOCK_SPEED = CLOCK_SPEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int BAUD_WIDTH = baud_width(CLOCK_SPEED, BAUD_RATE);
  localparam int HALF_WIDTH = BAUD_WIDTH / 2;
  localparam logic [COUNT_WIDTH-1:0] BAUD_LAST = COUNT_WIDTH'(BAUD_WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] HALF_LAST = COUNT_WIDTH'(HALF_WIDTH - 1);

  if (BAUD_WIDTH > (1 << COUNT_WIDTH) || BAUD_WIDTH < 2) begin : g_bad_baud
    $error("uart_rx: BAUD_WIDTH %0d does not fit the bit counter", BAUD_WIDTH);
  end

  logic                   rx_s;
  logic                   rx_q_reg;
  logic                   start_detect;
  state_t                 state_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic [2:0]             index_reg;
  logic [7:0]             shift_reg;

  sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign start_detect = rx_q_reg & ~rx_s;
  assign busy         = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q_reg  <= 1'b1;
      state_reg <= IDLE;
      count_reg <= '0;
      index_reg <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_q_reg  <= rx_s;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      unique case (state_reg)
        IDLE: begin
          if (start_detect) begin
            state_reg <= START;
            count_reg <= '0;
          end
        end
        START: begin
          if (count_reg == HALF_LAST) begin
            // A start bit that is high again at its mid-point was a glitch.
            state_reg <= rx_s ? IDLE : DATA;
            count_reg <= '0;
            index_reg <= '0;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        DATA: begin
          if (count_reg == BAUD_LAST) begin
            shift_reg <= {~rx_s, shift_reg[7:1]};
            count_reg <= '0;
            index_reg <= index_reg + 3'd1;
            if (index_reg == 3'd7) begin
              state_reg <= STOP;
            end
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        STOP: begin
          if (count_reg == BAUD_LAST) begin
            state_reg <= IDLE;
            count_reg <= '0;
            if (!rx_s) begin
              frame_err <= 1'b1;
            end else if (!rx_valid || rx_ready) begin
              // Overrides the accept clear above when both happen together.
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model plus directed scenarios.
module tb_uart_rx;

  localparam int CLOCK_SPEED = 1_000_000;
  localparam int BAUD_RATE   = 100_000;
  localparam int BW          = CLOCK_SPEED / BAUD_RATE;
  localparam int HW          = BW / 2;
  localparam int LAT         = 9 * BW + HW + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(.BAUD_RATE(BAUD_RATE), .CLOCK_SPEED(CLOCK_SPEED)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rst_e;
  logic ready_e;

  // Inputs as seen by the DUT at each rising edge.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_e   <= rst;
    ready_e <= rx_ready;
  end

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       stop_ok;
  } commit_t;

  typedef struct {
    int   cyc;
    logic val;
  } busy_t;

  commit_t commit_q[$];
  busy_t   busy_q[$];

  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_fe = 1'b0;
  logic       m_ov = 1'b0;
  bit         armed = 1'b0;

  logic       prev_valid = 1'b0;
  int         last_rise = -1;
  logic [7:0] last_data = 8'h00;
  int         rises = 0;
  int         fe_count = 0;
  int         ov_count = 0;
  int         last_fall = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model and per-cycle compare.
  initial begin
    commit_t c;
    logic    was_valid;
    forever begin
      @(negedge clk);
      if (rst_e === 1'b1) begin
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
        commit_q.delete();
        busy_q.delete();
        armed   = 1'b1;
        check("busy_in_reset", busy, 1'b0);
      end else if (armed) begin
        was_valid = m_valid;
        m_fe = 1'b0;
        m_ov = 1'b0;
        if (was_valid && ready_e) m_valid = 1'b0;
        if (commit_q.size() > 0 && commit_q[0].cyc == cyc) begin
          c = commit_q.pop_front();
          if (!c.stop_ok) m_fe = 1'b1;
          else if (!was_valid || ready_e) begin
            m_data  = c.data;
            m_valid = 1'b1;
          end else m_ov = 1'b1;
        end
        while (busy_q.size() > 0 && busy_q[0].cyc <= cyc) begin
          if (busy_q[0].cyc == cyc) check("busy", busy, busy_q[0].val);
          void'(busy_q.pop_front());
        end
      end
      if (armed) begin
        if (rx_valid === 1'b1 && !prev_valid) begin
          last_rise = cyc;
          last_data = rx_data;
          rises++;
        end
        prev_valid = (rx_valid === 1'b1);
        if (frame_err === 1'b1) fe_count++;
        if (overrun === 1'b1) ov_count++;
        check("rx_valid", rx_valid, m_valid);
        check("rx_data", rx_data, m_data);
        check("frame_err", frame_err, m_fe);
        check("overrun", overrun, m_ov);
      end
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // ready_pulse/rst_at are cycle offsets within the frame, -1 when unused.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int ready_pulse, input int rst_at);
    logic [9:0] line;
    int         f;
    line = {stop_bit, ~b, 1'b0};
    f = 0;
    for (int i = 0; i < 10 * BW; i++) begin
      @(negedge clk);
      if (i == 0) begin
        f = cyc;
        last_fall = f;
        commit_q.push_back('{f + LAT, b, stop_bit});
        busy_q.push_back('{f + 50, 1'b1});
        busy_q.push_back('{f + LAT + 1, 1'b0});
      end
      rx = line[i / BW];
      if (ready_pulse >= 0) rx_ready = (i == ready_pulse);
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        $display("frame %02h abandoned by reset at offset %0d (cycle %0d)", b, i, cyc);
        return;
      end
    end
    $display("frame %02h stop=%0b started at cycle %0d", b, stop_bit, f);
  endtask

  initial begin
    int f;
    int r0;
    int fe0;
    int ov0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_busy", busy, 1'b0);
    idle(5);

    // 1: plain frame, consumer always ready
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, -1, -1);
    f = last_fall;
    idle(10);
    check("t1_latency", last_rise - f, 98);
    check("t1_data", last_data, 8'hA5);
    check("t1_no_flags", fe_count + ov_count, 0);

    // 2: 3-cycle glitch
    r0 = rises;
    @(negedge clk);
    rx = 1'b0;
    busy_q.push_back('{cyc + 5, 1'b1});
    busy_q.push_back('{cyc + 12, 1'b0});
    repeat (3) @(negedge clk);
    idle(20);
    $display("glitch done at cycle %0d", cyc);
    check("t2_no_byte", rises, r0);
    check("t2_no_flags", fe_count + ov_count, 0);

    // 3: framing error then a good frame
    fe0 = fe_count;
    r0  = rises;
    send_frame(8'h3C, 1'b0, -1, -1);
    idle(20);
    check("t3_frame_err", fe_count - fe0, 1);
    check("t3_no_byte", rises, r0);
    send_frame(8'h81, 1'b1, -1, -1);
    idle(10);
    check("t3_data", last_data, 8'h81);

    // 4: overrun with consumer stalled
    rx_ready = 1'b0;
    ov0 = ov_count;
    send_frame(8'h3C, 1'b1, -1, -1);
    send_frame(8'hC3, 1'b1, -1, -1);
    idle(5);
    check("t4_overrun", ov_count - ov0, 1);
    check("t4_held", rx_data, 8'h3C);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_cleared", rx_valid, 1'b0);
    check("t4_data_kept", rx_data, 8'h3C);

    // 5: reset during data bit 4
    idle(10);
    send_frame(8'h0F, 1'b1, -1, 5 * BW + 5);
    check("t5_busy", busy, 1'b0);
    check("t5_data", rx_data, 8'h00);
    idle(30);
    send_frame(8'h55, 1'b1, -1, -1);
    idle(10);
    check("t5_after", last_data, 8'h55);

    // 6: accept coinciding with the stop sample
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, -1, -1);
    idle(5);
    ov0 = ov_count;
    send_frame(8'hF0, 1'b1, 97, -1);
    idle(5);
    check("t6_data", rx_data, 8'hF0);
    check("t6_valid", rx_valid, 1'b1);
    check("t6_no_overrun", ov_count - ov0, 0);
    rx_ready = 1'b1;
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: the receive end of the team's uart_tx link (start bit 0, 8 payload bits LSB first, stop bit 1).
- Link convention: payload bits travel inverted on the line. uart_rx re-inverts them, so rx_data equals the byte given to the transmitter.
- Synchronises the asynchronous rx pin, samples each bit at mid-bit, and presents bytes on a valid/ready holding register with framing-error and overrun flags.

Parameters:
- BAUD_RATE, 115_200, line bit rate in bit/s.
- CLOCK_SPEED, 50_000_000, clk frequency in Hz.
- BAUD_WIDTH, int'(CLOCK_SPEED/BAUD_RATE) (434 at defaults), clk cycles per bit. Derived; must not be overridden independently.
- HALF_WIDTH, BAUD_WIDTH/2 (217 at defaults), cycles from start-bit edge to the start-bit mid-point.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line; idles high.
- rx_ready  in  1  consumer accepts the held byte when rx_valid && rx_ready.
- rx_data  out  8  received byte, already re-inverted.
- rx_valid  out  1  level; high while a byte is held.
- frame_err  out  1  one-cycle pulse; stop bit sampled low.
- overrun  out  1  one-cycle pulse; a frame completed while the previous byte was still held.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Input synchroniser: rx passes through 2 flops to give rx_s; a third flop gives rx_q. All three reset to 1.
- Start detect: fires when rx_q=1 and rx_s=0 (falling edge). A line held low never re-triggers.
- State machine: one-hot states IDLE, START, DATA, STOP. Registers: 9-bit cycle counter, 3-bit bit index, 8-bit shift register.
- IDLE: on start detect, go to START with counter=0.
- START:
  - counter increments.
  - At counter==HALF_WIDTH-1, sample rx_s. If 0, go to DATA with counter=0 and bit index=0. If 1 (glitch/false start), return to IDLE with no flags.
- DATA:
  - At counter==BAUD_WIDTH-1 (mid-bit), shift ~rx_s in at the MSB end (right shift, so LSB arrives first), reset counter to 0, increment bit index.
  - After the 8th sample (index 7), go to STOP.
- STOP: at counter==BAUD_WIDTH-1, sample rx_s, then go to IDLE.
  - rx_s=1 and no byte held, or held byte consumed this cycle: load rx_data, set rx_valid on the next cycle.
  - rx_s=1 and byte held with rx_ready=0: keep the old byte, discard the new one, pulse overrun.
  - rx_s=0: pulse frame_err, discard the byte, leave rx_valid/rx_data unchanged.
- Holding register:
  - rx_valid clears the cycle after rx_valid && rx_ready.
  - A commit in the same cycle as an accept loads the new byte and keeps rx_valid=1, with no overrun.
- Latency: rx_valid rises 9*BAUD_WIDTH + HALF_WIDTH + 3 cycles (±1) after the falling edge at the rx pin.
- Reset values: rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, counters=0. Reset mid-frame abandons the frame immediately.
- Width rules:
  - Counter is 9 bits; BAUD_WIDTH ≤ 512 is required and checked by an elaboration assertion.
  - Bit index wraps at 7→0 only via the DATA→STOP transition.
- rx_ready while rx_valid=0 has no effect.

Decomposition:
- Shared package uart_pkg holds:
  - BAUD_RATE/CLOCK_SPEED defaults and the BAUD_WIDTH derivation.
  - packet_t (stop_bit, payload[7:0], start_bit), reused by uart_tx.
  - The state-bit enum and one-hot state enum.
- One sub-module: sync_2ff (parameterised reset value, 1 bit) for the rx synchroniser.

Test Plan (CLOCK_SPEED=1_000_000, BAUD_RATE=100_000, so BAUD_WIDTH=10, HALF_WIDTH=5):
1. Frame carrying byte 0xA5: line payload 0x5A, LSB first, 10 cycles per bit, rx_ready=1 -> rx_valid for 1 cycle, rx_data=0xA5, no frame_err/overrun; rx_valid rises 98±1 cycles after the start edge.
2. rx low for 3 cycles, then high -> busy high briefly, back to IDLE, rx_valid/frame_err/overrun stay 0.
3. Frame for 0x3C with stop bit driven low, then line high, then a valid 0x81 frame -> frame_err pulses once and rx_valid stays 0; the second frame gives rx_data=0x81.
4. rx_ready=0, frames 0x3C then 0xC3 back-to-back -> rx_data=0x3C held, overrun pulses at end of second frame; after rx_ready=1, rx_valid clears and rx_data stays 0x3C.
5. rst asserted for 1 cycle midway through DATA bit 4 of a frame -> all outputs 0 next cycle, busy=0; a following 0x55 frame is received correctly.
6. Byte held, rx_ready=1 pulsed in the exact stop-sample cycle of frame 0xF0 -> rx_data=0xF0, rx_valid stays 1, overrun=0.
